// File: rtl/bus_resp.sv
// rtl/bus_resp.sv - CPU-side bus responder: address fold/decode, wait states, fabric handshake
module bus_resp #(
    parameter logic [7:0]  RAM_TOP    = 8'h08,
    parameter logic [15:0] IO_PAGE    = 16'h00C0,
    parameter logic [7:0]  ROM_BANK   = 8'hFF,
    parameter int          RAM_WS     = 0,
    parameter int          ROM_WS     = 1,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        VALID,
    input  logic [23:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    input  logic        ABWDTH,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        ERR,
    output logic [2:0]  mem_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam logic [3:0]  RAM_WS_C = 4'(RAM_WS);
    localparam logic [3:0]  ROM_WS_C = 4'(ROM_WS);
    localparam logic [15:0] TO_LAST  = 16'(IO_TIMEOUT - 1);

    localparam logic [2:0] SEL_RAM = 3'b001;
    localparam logic [2:0] SEL_ROM = 3'b010;
    localparam logic [2:0] SEL_IO  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE,
        S_ERRD
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [23:0] eff_addr;
    logic [2:0]  region;
    logic [3:0]  region_ws;
    logic        we_q;
    logic [3:0]  wait_cnt;
    logic [15:0] to_cnt;
    logic        is_io;
    logic        is_rom;
    logic        is_ram;

    // 16-bit mode folds the top 4K page into the ROM bank so reset vectors resolve.
    always_comb begin
        eff_addr = AB;
        if (!ABWDTH) begin
            if (AB[15:12] == 4'hF) begin
                eff_addr = {ROM_BANK, AB[15:0]};
            end else begin
                eff_addr = {8'h00, AB[15:0]};
            end
        end
    end

    always_comb begin
        region = 3'b000;
        if (eff_addr[23:8] == IO_PAGE) begin
            region = SEL_IO;
        end else if (eff_addr[23:16] == ROM_BANK) begin
            region = SEL_ROM;
        end else if (eff_addr[23:16] < RAM_TOP) begin
            region = SEL_RAM;
        end
    end

    always_comb begin
        case (region)
            SEL_RAM: region_ws = RAM_WS_C;
            SEL_ROM: region_ws = ROM_WS_C;
            default: region_ws = 4'd0;
        endcase
    end

    assign is_io  = mem_sel[2];
    assign is_rom = mem_sel[1];
    assign is_ram = mem_sel[0];

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        RDY       = 1'b0;
        ERR       = 1'b0;
        case (state)
            S_IDLE: begin
                if (VALID) begin
                    if (region == 3'b000) begin
                        state_nxt = S_ERRD;
                    end else if (region_ws != 4'd0) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (is_io) begin
                    mem_req = 1'b1;
                    mem_we  = we_q;
                    if (mem_ack) begin
                        state_nxt = S_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        state_nxt = S_ERRD;
                    end
                end else begin
                    // ROM writes never reach the fabric.
                    mem_req   = !(is_rom && we_q);
                    mem_we    = is_ram && we_q;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                RDY       = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERRD: begin
                RDY       = 1'b1;
                ERR       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            DI        <= 8'h00;
            mem_sel   <= 3'b000;
            mem_addr  <= 24'h000000;
            mem_wdata <= 8'h00;
            we_q      <= 1'b0;
            wait_cnt  <= 4'd0;
            to_cnt    <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (VALID) begin
                        mem_addr  <= eff_addr;
                        mem_wdata <= DO;
                        we_q      <= WE;
                        mem_sel   <= region;
                        wait_cnt  <= region_ws;
                        to_cnt    <= 16'd0;
                        if (region == 3'b000) begin
                            DI <= 8'hFF;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                S_ACCESS: begin
                    if (is_io) begin
                        to_cnt <= to_cnt + 16'd1;
                        if (mem_ack) begin
                            if (!we_q) begin
                                DI <= mem_rdata;
                            end
                            mem_sel <= 3'b000;
                        end else if (to_cnt == TO_LAST) begin
                            DI      <= 8'hFF;
                            mem_sel <= 3'b000;
                        end
                    end else begin
                        if (!we_q) begin
                            DI <= mem_rdata;
                        end
                        mem_sel <= 3'b000;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_resp.sv
// tb/tb_bus_resp.sv - directed self-checking bench for bus_resp
module tb_bus_resp;

    logic        clk;
    logic        RST;
    logic        VALID;
    logic [23:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic        ABWDTH;
    logic [7:0]  DI;
    logic        RDY;
    logic        ERR;
    logic [2:0]  mem_sel;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int tests_run;
    int tests_failed;

    bus_resp dut (
        .clk       (clk),
        .RST       (RST),
        .VALID     (VALID),
        .AB        (AB),
        .DO        (DO),
        .WE        (WE),
        .ABWDTH    (ABWDTH),
        .DI        (DI),
        .RDY       (RDY),
        .ERR       (ERR),
        .mem_sel   (mem_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) step();
        tests_run++; if (DI !== 8'h00) begin tests_failed++; $display("FAIL reset_di: got %h want 00", DI); end
        tests_run++; if (RDY !== 1'b0 || ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy_err: got %b%b want 00", RDY, ERR); end
        tests_run++; if (mem_sel !== 3'b000 || mem_req !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_ctl: got sel=%b req=%b we=%b want 000/0/0", mem_sel, mem_req, mem_we); end
        tests_run++; if (mem_addr !== 24'h0 || mem_wdata !== 8'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h/%h want 000000/00", mem_addr, mem_wdata); end
        RST = 1'b1;
        step();
    endtask

    task automatic test_ram();
        AB = 24'h000123; ABWDTH = 1'b1; WE = 1'b0; mem_rdata = 8'h5A; VALID = 1'b1;
        step();
        VALID = 1'b0;
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL ram_rd_req: got req=%b we=%b want 1/0", mem_req, mem_we); end
        tests_run++; if (mem_sel !== 3'b001 || mem_addr !== 24'h000123) begin tests_failed++; $display("FAIL ram_rd_sel: got %b %h want 001 000123", mem_sel, mem_addr); end
        tests_run++; if (RDY !== 1'b0) begin tests_failed++; $display("FAIL ram_rd_early_rdy: got %b want 0", RDY); end
        step();
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b0 || DI !== 8'h5A) begin tests_failed++; $display("FAIL ram_rd_done: got rdy=%b err=%b di=%h want 1/0/5a", RDY, ERR, DI); end
        tests_run++; if (mem_req !== 1'b0 || mem_sel !== 3'b000) begin tests_failed++; $display("FAIL ram_rd_done_ctl: got req=%b sel=%b want 0/000", mem_req, mem_sel); end
        step();
        tests_run++; if (RDY !== 1'b0 || DI !== 8'h5A) begin tests_failed++; $display("FAIL ram_rd_hold: got rdy=%b di=%h want 0/5a", RDY, DI); end

        AB = 24'h7F1234; ABWDTH = 1'b0; mem_rdata = 8'h6B; VALID = 1'b1;
        step();
        VALID = 1'b0;
        tests_run++; if (mem_addr !== 24'h001234 || mem_sel !== 3'b001 || mem_req !== 1'b1) begin tests_failed++; $display("FAIL ram16_fold: got %h sel=%b req=%b want 001234/001/1", mem_addr, mem_sel, mem_req); end
        step();
        tests_run++; if (RDY !== 1'b1 || DI !== 8'h6B) begin tests_failed++; $display("FAIL ram16_done: got rdy=%b di=%h want 1/6b", RDY, DI); end
        step();

        AB = 24'h000456; ABWDTH = 1'b1; WE = 1'b1; DO = 8'hA7; VALID = 1'b1;
        step();
        VALID = 1'b0; WE = 1'b0;
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'hA7) begin tests_failed++; $display("FAIL ram_wr: got req=%b we=%b wd=%h want 1/1/a7", mem_req, mem_we, mem_wdata); end
        step();
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b0 || DI !== 8'h6B) begin tests_failed++; $display("FAIL ram_wr_done: got rdy=%b err=%b di=%h want 1/0/6b", RDY, ERR, DI); end
        step();
    endtask

    task automatic test_rom();
        AB = 24'h00FFFC; ABWDTH = 1'b0; WE = 1'b0; mem_rdata = 8'hC3; VALID = 1'b1;
        step();
        VALID = 1'b0;
        tests_run++; if (mem_addr !== 24'hFFFFFC || mem_sel !== 3'b010 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL rom_wait: got %h sel=%b req=%b want fffffc/010/0", mem_addr, mem_sel, mem_req); end
        step();
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || RDY !== 1'b0) begin tests_failed++; $display("FAIL rom_access: got req=%b we=%b rdy=%b want 1/0/0", mem_req, mem_we, RDY); end
        step();
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b0 || DI !== 8'hC3) begin tests_failed++; $display("FAIL rom_done: got rdy=%b err=%b di=%h want 1/0/c3", RDY, ERR, DI); end
        step();

        WE = 1'b1; DO = 8'h77; VALID = 1'b1;
        step();
        VALID = 1'b0; WE = 1'b0;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rom_wr_wait: got req=%b want 0", mem_req); end
        step();
        tests_run++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || RDY !== 1'b0) begin tests_failed++; $display("FAIL rom_wr_access: got req=%b we=%b rdy=%b want 0/0/0", mem_req, mem_we, RDY); end
        step();
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b0 || DI !== 8'hC3) begin tests_failed++; $display("FAIL rom_wr_done: got rdy=%b err=%b di=%h want 1/0/c3", RDY, ERR, DI); end
        step();
    endtask

    task automatic test_back_to_back();
        AB = 24'h000200; ABWDTH = 1'b1; WE = 1'b0; mem_rdata = 8'h11; VALID = 1'b1;
        step();
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 24'h000200) begin tests_failed++; $display("FAIL b2b_first_req: got req=%b addr=%h want 1/000200", mem_req, mem_addr); end
        step();
        tests_run++; if (RDY !== 1'b1 || DI !== 8'h11) begin tests_failed++; $display("FAIL b2b_first_done: got rdy=%b di=%h want 1/11", RDY, DI); end
        AB = 24'h000300; mem_rdata = 8'h22;
        step();
        tests_run++; if (mem_req !== 1'b0 || RDY !== 1'b0 || mem_addr !== 24'h000200) begin tests_failed++; $display("FAIL b2b_done_ignored: got req=%b rdy=%b addr=%h want 0/0/000200", mem_req, RDY, mem_addr); end
        step();
        VALID = 1'b0;
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 24'h000300) begin tests_failed++; $display("FAIL b2b_second_req: got req=%b addr=%h want 1/000300", mem_req, mem_addr); end
        step();
        tests_run++; if (RDY !== 1'b1 || DI !== 8'h22) begin tests_failed++; $display("FAIL b2b_second_done: got rdy=%b di=%h want 1/22", RDY, DI); end
        step();
    endtask

    task automatic test_io();
        AB = 24'h00C010; ABWDTH = 1'b1; WE = 1'b1; DO = 8'h3C; VALID = 1'b1;
        step();
        VALID = 1'b0; WE = 1'b0;
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'h3C || mem_sel !== 3'b100) begin tests_failed++; $display("FAIL io_wr_c1: got req=%b we=%b wd=%h sel=%b want 1/1/3c/100", mem_req, mem_we, mem_wdata, mem_sel); end
        step();
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || RDY !== 1'b0) begin tests_failed++; $display("FAIL io_wr_c2: got req=%b we=%b rdy=%b want 1/1/0", mem_req, mem_we, RDY); end
        step();
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || RDY !== 1'b0) begin tests_failed++; $display("FAIL io_wr_c3: got req=%b we=%b rdy=%b want 1/1/0", mem_req, mem_we, RDY); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b0 || mem_req !== 1'b0 || DI !== 8'h22) begin tests_failed++; $display("FAIL io_wr_done: got rdy=%b err=%b req=%b di=%h want 1/0/0/22", RDY, ERR, mem_req, DI); end
        step();

        AB = 24'h00C0AB; mem_rdata = 8'hA5; VALID = 1'b1;
        step();
        VALID = 1'b0;
        tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL io_rd_req: got req=%b we=%b want 1/0", mem_req, mem_we); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b0 || DI !== 8'hA5) begin tests_failed++; $display("FAIL io_rd_done: got rdy=%b err=%b di=%h want 1/0/a5", RDY, ERR, DI); end
        step();
    endtask

    task automatic test_unmapped();
        logic [23:0] addrs [2];
        addrs[0] = 24'h400000;
        addrs[1] = 24'h080000;
        AB = 24'h07FFFF; ABWDTH = 1'b1; WE = 1'b0; mem_rdata = 8'h3D; VALID = 1'b1;
        step();
        VALID = 1'b0;
        tests_run++; if (mem_sel !== 3'b001 || mem_req !== 1'b1) begin tests_failed++; $display("FAIL ram_top_edge: got sel=%b req=%b want 001/1", mem_sel, mem_req); end
        step();
        tests_run++; if (RDY !== 1'b1 || DI !== 8'h3D) begin tests_failed++; $display("FAIL ram_top_done: got rdy=%b di=%h want 1/3d", RDY, DI); end
        step();
        for (int i = 0; i < 2; i++) begin
            AB = addrs[i]; VALID = 1'b1;
            step();
            VALID = 1'b0;
            tests_run++; if (RDY !== 1'b1 || ERR !== 1'b1 || DI !== 8'hFF) begin tests_failed++; $display("FAIL unmapped_%0d: got rdy=%b err=%b di=%h want 1/1/ff", i, RDY, ERR, DI); end
            tests_run++; if (mem_req !== 1'b0 || mem_sel !== 3'b000) begin tests_failed++; $display("FAIL unmapped_ctl_%0d: got req=%b sel=%b want 0/000", i, mem_req, mem_sel); end
            step();
            tests_run++; if (RDY !== 1'b0 || ERR !== 1'b0) begin tests_failed++; $display("FAIL unmapped_end_%0d: got rdy=%b err=%b want 0/0", i, RDY, ERR); end
        end
    endtask

    task automatic test_io_timeout();
        int req_cycles;
        int guard;
        AB = 24'h000010; ABWDTH = 1'b1; WE = 1'b0; mem_rdata = 8'h12; VALID = 1'b1;
        step();
        VALID = 1'b0;
        step();
        tests_run++; if (DI !== 8'h12) begin tests_failed++; $display("FAIL timeout_pre: got di=%h want 12", DI); end
        step();
        AB = 24'h00C055; mem_ack = 1'b0; VALID = 1'b1;
        step();
        VALID = 1'b0;
        req_cycles = 0;
        guard = 0;
        while (mem_req === 1'b1 && guard < 40) begin
            req_cycles++;
            guard++;
            step();
        end
        tests_run++; if (req_cycles != 16) begin tests_failed++; $display("FAIL timeout_req_cycles: got %0d want 16", req_cycles); end
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b1 || DI !== 8'hFF || mem_req !== 1'b0) begin tests_failed++; $display("FAIL timeout_errd: got rdy=%b err=%b di=%h req=%b want 1/1/ff/0", RDY, ERR, DI, mem_req); end
        step();
        tests_run++; if (RDY !== 1'b0) begin tests_failed++; $display("FAIL timeout_end: got rdy=%b want 0", RDY); end
    endtask

    task automatic test_reset_mid();
        logic saw_rdy;
        AB = 24'h00C020; ABWDTH = 1'b1; WE = 1'b0; mem_ack = 1'b0; VALID = 1'b1;
        step();
        VALID = 1'b0;
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rstmid_req: got %b want 1", mem_req); end
        step();
        #1 RST = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || RDY !== 1'b0 || ERR !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctl: got req=%b we=%b rdy=%b err=%b want 0/0/0/0", mem_req, mem_we, RDY, ERR); end
        tests_run++; if (mem_sel !== 3'b000 || mem_addr !== 24'h0 || mem_wdata !== 8'h0 || DI !== 8'h00) begin tests_failed++; $display("FAIL rstmid_regs: got sel=%b addr=%h wd=%h di=%h want 000/000000/00/00", mem_sel, mem_addr, mem_wdata, DI); end
        step();
        RST = 1'b1;
        saw_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (RDY !== 1'b0) saw_rdy = 1'b1;
        end
        tests_run++; if (saw_rdy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_rdy: got %b want 0", saw_rdy); end
        AB = 24'h000045; mem_rdata = 8'h99; VALID = 1'b1;
        step();
        VALID = 1'b0;
        tests_run++; if (mem_req !== 1'b1 || mem_sel !== 3'b001) begin tests_failed++; $display("FAIL rstmid_after_req: got req=%b sel=%b want 1/001", mem_req, mem_sel); end
        step();
        tests_run++; if (RDY !== 1'b1 || ERR !== 1'b0 || DI !== 8'h99) begin tests_failed++; $display("FAIL rstmid_after_done: got rdy=%b err=%b di=%h want 1/0/99", RDY, ERR, DI); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST       = 1'b0;
        VALID     = 1'b0;
        AB        = 24'h0;
        DO        = 8'h0;
        WE        = 1'b0;
        ABWDTH    = 1'b1;
        mem_rdata = 8'h0;
        mem_ack   = 1'b0;
        test_reset();
        test_ram();
        test_rom();
        test_back_to_back();
        test_io();
        test_unmapped();
        test_io_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_resp.md
Name: bus_resp

Overview:
- CPU-side bus responder for the 65C24T8 core; the target end of the 24-bit address bus that the CPU address generator drives.
- Latches each CPU request and maps the address to an effective 24-bit address, folding it in 16-bit mode.
- Decodes the effective address into RAM, IO or ROM, inserts per-region wait states and runs a req/ack handshake to the memory/IO fabric.
- Returns read data with a one-cycle RDY pulse.

Parameters:
- RAM_TOP, 8'h08: effective AB[23:16] < RAM_TOP selects RAM.
- IO_PAGE, 16'h00C0: effective AB[23:8] == IO_PAGE selects IO.
- ROM_BANK, 8'hFF: effective AB[23:16] == ROM_BANK selects ROM.
- RAM_WS, 0: RAM wait states (0..15).
- ROM_WS, 1: ROM wait states (0..15).
- IO_TIMEOUT, 16: maximum IO cycles waiting for mem_ack before abort.

Ports:
- clk  in  1  clock
- RST  in  1  asynchronous active-low reset
- VALID  in  1  CPU request strobe
- AB  in  24  CPU address
- DO  in  8  CPU write data
- WE  in  1  1 = write
- ABWDTH  in  1  1 = 24-bit bus, 0 = 16-bit bus
- DI  out  8  read data to CPU
- RDY  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle error pulse, coincident with RDY
- mem_sel  out  3  one-hot {IO, ROM, RAM}
- mem_req  out  1  fabric request
- mem_we  out  1  fabric write enable
- mem_addr  out  24  effective address
- mem_wdata  out  8  write data
- mem_rdata  in  8  fabric read data
- mem_ack  in  1  IO completion (used for IO only)

Behaviour:
- Effective address:
  - ABWDTH=1: AB unchanged.
  - ABWDTH=0 and AB[15:12]==4'hF: {ROM_BANK, AB[15:0]}, so reset vectors are reachable.
  - ABWDTH=0 otherwise: {8'h00, AB[15:0]}.
- Decode priority: IO, then ROM, then RAM, else unmapped.
- Reset (RST low, asynchronous): state IDLE; DI=8'h00; RDY=0; ERR=0; mem_sel=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; wait and timeout counters=0. A reset mid-transaction drops mem_req immediately and abandons the access with no RDY.
- IDLE:
  - VALID=1 latches effective address, DO, WE and region.
  - mem_addr, mem_wdata and mem_sel are held from the latch until the transaction ends.
  - Next state is WAIT if the region's wait count > 0; ACCESS otherwise; ERRD if unmapped.
  - VALID is ignored in every other state; the CPU holds the bus until RDY.
- WAIT: decrement the counter loaded with RAM_WS or ROM_WS; go to ACCESS when it reaches 1.
- ACCESS, RAM/ROM:
  - mem_req=1 for exactly one cycle; mem_we=WE (RAM only).
  - Capture mem_rdata at the end of that cycle; next state DONE.
- ACCESS, ROM write: mem_req=0 and mem_we=0; write silently dropped; DONE with no ERR.
- ACCESS, IO:
  - mem_req and mem_we held until mem_ack=1; capture mem_rdata in the ack cycle; then DONE.
  - If mem_ack has not arrived after IO_TIMEOUT ACCESS cycles: drop mem_req and go to ERRD.
  - mem_ack outside IO ACCESS is ignored.
- DONE: RDY=1 for one cycle; DI=captured data (unchanged on writes); mem_sel cleared; return to IDLE.
- ERRD: RDY=1, ERR=1, DI=8'hFF for one cycle; then IDLE.
- Latency, VALID in cycle n:
  - RAM/ROM: RDY in cycle n+2+WS.
  - IO: RDY one cycle after the ack cycle.
  - Unmapped: RDY in cycle n+1.
- A back-to-back VALID in the DONE cycle is ignored; it is accepted the next cycle from IDLE.
- DI holds its value between transactions.

Test Plan:
1. Reset, then VALID read AB=24'h000123, ABWDTH=1, RAM_WS=0, mem_rdata=8'h5A -> mem_sel=001, one mem_req pulse in cycle n+1, RDY with DI=8'h5A in n+2, ERR=0.
2. ABWDTH=0, AB=24'h00FFFC read, ROM_WS=1 -> mem_addr=24'hFFFFFC, mem_sel=010, RDY in n+3; then write to the same address -> no mem_req, RDY with ERR=0.
3. IO write AB=24'h00C010, DO=8'h3C, mem_ack after 3 cycles -> mem_req/mem_we held 3 cycles, mem_wdata=8'h3C, RDY the cycle after ack.
4. IO read with mem_ack never asserted -> mem_req dropped after 16 cycles, then RDY=1, ERR=1, DI=8'hFF.
5. Read AB=24'h400000 (unmapped) -> no mem_req, RDY and ERR in n+1, DI=8'hFF.
6. RST asserted during an IO ACCESS -> mem_req=0 and all outputs at reset values immediately; no RDY after release; next VALID is serviced normally.
